// File: rtl/hififo_pkg.sv
// Shared types and helpers for the hififo write-request arbitration path.
package hififo_pkg;

  localparam int HIFIFO_WR_W   = 66;
  localparam int HIFIFO_WR_EOP = 65;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Round-robin successor of ptr among n requesters.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/hififo_rr_pick.sv
// Combinational rotating-priority encoder: first candidate at or after ptr, wrapping modulo N.
module hififo_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  candidates,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit keeps ptr+k exact before the modulo fold for non-power-of-two N.
      w_sum = {1'b0, ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) begin
        w_sum = w_sum - (PW+1)'(N);
      end
      w_idx = w_sum[PW-1:0];
      if (!any && candidates[w_idx]) begin
        pick[w_idx] = 1'b1;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hififo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing the pcie_tx write-request port between tpc FIFOs.
// Optional per-requester packet counters are enabled with HIFIFO_WR_ARB_STATS_EN.
module hififo_wr_arbiter
  import hififo_pkg::*;
#(
  parameter int N = 4,
  parameter int W = HIFIFO_WR_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  input  logic [N-1:0]   req_mask,
  output logic           wr_valid,
  output logic [W-1:0]   wr_data,
  input  logic           wr_ready,
  output logic [N-1:0]   grant,
  output logic           busy
`ifdef HIFIFO_WR_ARB_STATS_EN
  ,
  input  logic           stats_clear,
  output logic [N*32-1:0] pkt_count
`endif
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_gidx;
  logic [N-1:0]  r_grant;
  logic          r_busy;

  logic [W-1:0]  w_beat [N];
  logic [N-1:0]  w_cand;
  logic [N-1:0]  w_pick;
  logic          w_any;
  logic [PW-1:0] w_pick_idx;
  logic          w_eop_xfer;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_beat
      assign w_beat[gi] = req_data[gi*W +: W];
    end
  endgenerate

  assign w_cand = req_valid & ~req_mask;

  hififo_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .candidates (w_cand),
    .ptr        (r_ptr),
    .pick       (w_pick),
    .any        (w_any)
  );

  always_comb begin
    w_pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PW'(i);
      end
    end
  end

  // Owner's handshake passes straight through so the lock adds no latency or buffering.
  assign wr_valid   = r_busy & req_valid[r_gidx];
  assign wr_data    = r_busy ? w_beat[r_gidx] : '0;
  assign req_ready  = r_grant & {N{wr_ready}};
  assign w_eop_xfer = wr_valid & wr_ready & wr_data[W-1];
  assign grant      = r_grant;
  assign busy       = r_busy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state <= ARB_BUSY;
            r_grant <= w_pick;
            r_gidx  <= w_pick_idx;
            r_busy  <= 1'b1;
          end
        end
        ARB_BUSY: begin
          if (w_eop_xfer) begin
            r_state <= ARB_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= PW'(rr_next(int'(r_gidx), N));
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef HIFIFO_WR_ARB_STATS_EN
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_stats
      logic [31:0] r_cnt;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (stats_clear) begin
          r_cnt <= '0;
        end else if (w_eop_xfer && (r_gidx == PW'(gi))) begin
          r_cnt <= r_cnt + 32'd1;
        end
      end
      assign pkt_count[gi*32 +: 32] = r_cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_hififo_wr_arbiter.sv
// Scoreboard bench for hififo_wr_arbiter: sources model tpc FIFOs, a monitor checks every beat sent to pcie_tx.
module tb_hififo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 66;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_mask;
  logic           wr_valid;
  logic [W-1:0]   wr_data;
  logic           wr_ready;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef HIFIFO_WR_ARB_STATS_EN
  logic           stats_clear;
  logic [N*32-1:0] pkt_count;
`endif

  always #5 clock = ~clock;

  hififo_wr_arbiter #(.N(N), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .req_mask  (req_mask),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .grant     (grant),
    .busy      (busy)
`ifdef HIFIFO_WR_ARB_STATS_EN
    ,
    .stats_clear (stats_clear),
    .pkt_count   (pkt_count)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    int           req;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] src_q[N][$];
  logic [N-1:0] stall = '0;
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int r, input int p, input int b, input bit eop);
    logic [W-1:0] v;
    v        = '0;
    v[W-1]   = eop;
    v[63:56] = 8'(r);
    v[47:40] = 8'hA5 ^ 8'(b);
    v[15:8]  = 8'(p);
    v[7:0]   = 8'(b);
    return v;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !stall[i]) begin
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = src_q[i][0];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*W +: W]   = '0;
      end
    end
  endtask

  task automatic to_src(input int r, input int p, input int nb);
    for (int b = 0; b < nb; b++) src_q[r].push_back(mk(r, p, b, b == nb - 1));
  endtask

  // Expect the first 'upto' beats of an nb-beat packet from requester r.
  task automatic to_exp(input int r, input int p, input int nb, input int upto);
    exp_t e;
    for (int b = 0; b < upto; b++) begin
      e.data = mk(r, p, b, b == nb - 1);
      e.req  = r;
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_busy(input string name);
    int t;
    t = 0;
    @(negedge clock);
    while (!busy && t < 50) begin
      @(negedge clock);
      t++;
    end
    check(name, 128'(busy), 128'(1'b1));
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clock);
      t++;
    end
    check(name, 128'(exp_q.size() == 0 && !busy), 128'(1'b1));
  endtask

  // Source model: pop a beat once its handshake has completed.
  initial begin
    logic [N-1:0] xfer;
    forever begin
      @(negedge clock);
      xfer = req_valid & req_ready;
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      drive();
    end
  end

  // Monitor: every transferred beat must match the scoreboard head, data and owner.
  initial begin
    exp_t         e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("foreign_ready", 128'(req_ready & ~grant), 128'(0));
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h expected no beat at %0t", wr_data, $time);
          end else begin
            e      = exp_q.pop_front();
            oh     = '0;
            oh[e.req] = 1'b1;
            check("beat_data", 128'(wr_data), 128'(e.data));
            check("beat_owner", 128'(grant), 128'(oh));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats, eops, bi, g;
    req_valid = '0;
    req_data  = '0;
    req_mask  = '0;
    wr_ready  = 1'b1;
`ifdef HIFIFO_WR_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    reset = 1'b1;
    @(negedge clock);
    check("rst_grant", 128'(grant), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_wr_valid", 128'(wr_valid), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_wr_data", 128'(wr_data), 128'(0));
    step();
    reset = 1'b0;

    // 1: all requesters saturated with 3-beat packets
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < N; r++) to_src(r, rnd*4 + r, 3);
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < N; r++) to_exp(r, rnd*4 + r, 3, 3);
    drive();
    wait_busy("t1_busy");
    beats = 0;
    eops  = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clock);
      if (wr_valid && wr_ready) begin
        beats++;
        if (wr_data[W-1]) eops++;
      end
    end
    check("t1_beats_in_16", 128'(beats), 128'(12));
    check("t1_pkts_in_16", 128'(eops), 128'(4));
    wait_drain("t1_drain");

    // 2: owner 1 stalls mid-packet while requester 2 waits
    step();
    to_src(1, 10, 4);
    to_src(2, 11, 2);
    to_exp(1, 10, 4, 4);
    to_exp(2, 11, 2, 2);
    drive();
    wait_busy("t2_busy");
    step();
    stall[1] = 1'b1;
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("t2_stall_grant", 128'(grant), 128'(4'b0010));
      check("t2_stall_wr_valid", 128'(wr_valid), 128'(0));
      check("t2_stall_ready2", 128'(req_ready[2]), 128'(0));
    end
    step();
    stall[1] = 1'b0;
    drive();
    wait_drain("t2_drain");

    // 3: mask skips requester 2 with rr_ptr=2
    step();
    to_src(1, 20, 1);
    to_exp(1, 20, 1, 1);
    drive();
    wait_drain("t3_setup_drain");
    step();
    req_mask = 4'b0100;
    to_src(3, 24, 1);
    to_src(0, 21, 1);
    to_src(1, 22, 1);
    to_src(2, 23, 1);
    to_exp(3, 24, 1, 1);
    to_exp(0, 21, 1, 1);
    to_exp(1, 22, 1, 1);
    drive();
    wait_drain("t3_drain");
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t3_masked_idle_grant", 128'(grant), 128'(0));
      check("t3_masked_idle_busy", 128'(busy), 128'(0));
    end
    step();
    req_mask = '0;
    to_exp(2, 23, 1, 1);
    wait_drain("t3_unmask_drain");

    // 4: mask the owner mid-packet
    step();
    to_src(3, 30, 3);
    to_src(3, 31, 2);
    to_exp(3, 30, 3, 3);
    drive();
    wait_busy("t4_busy");
    step();
    req_mask = 4'b1000;
    wait_drain("t4_owner_finish");
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("t4_masked_idle_grant", 128'(grant), 128'(0));
    end
    step();
    to_src(2, 32, 2);
    to_exp(2, 32, 2, 2);
    drive();
    wait_drain("t4_other_drain");
    step();
    req_mask = '0;
    to_exp(3, 31, 2, 2);
    wait_drain("t4_unmask_drain");

    // 5: wr_ready toggling during a 4-beat packet
    step();
    to_src(0, 40, 4);
    to_exp(0, 40, 4, 4);
    drive();
    wait_busy("t5_busy");
    bi = 1;
    g  = 0;
    while (bi < 4 && g < 20) begin
      step();
      wr_ready = ~wr_ready;
      @(negedge clock);
      if (!wr_ready) begin
        check("t5_hold_data", 128'(wr_data), 128'(mk(0, 40, bi, bi == 3)));
        check("t5_hold_valid", 128'(wr_valid), 128'(1'b1));
      end else begin
        bi++;
      end
      g++;
    end
    check("t5_all_beats", 128'(bi), 128'(4));
    wait_drain("t5_drain");
    wr_ready = 1'b1;

`ifdef HIFIFO_WR_ARB_STATS_EN
    check("stats_req1", 128'(pkt_count[1*32 +: 32]), 128'(32'd5));
`endif

    // 6: reset during beat 2 of a 4-beat packet from requester 2
    step();
    to_src(2, 50, 4);
    to_exp(2, 50, 4, 2);
    drive();
    wait_busy("t6_busy");
    step();
    step();
    reset = 1'b1;
    #1;
    check("t6_rst_grant", 128'(grant), 128'(0));
    check("t6_rst_wr_valid", 128'(wr_valid), 128'(0));
    check("t6_rst_req_ready", 128'(req_ready), 128'(0));
    check("t6_rst_busy", 128'(busy), 128'(0));
`ifdef HIFIFO_WR_ARB_STATS_EN
    check("t6_rst_stats", 128'(pkt_count), 128'(0));
`endif
    for (int i = 0; i < N; i++) src_q[i].delete();
    to_src(0, 51, 1);
    to_src(2, 52, 1);
    to_exp(0, 51, 1, 1);
    to_exp(2, 52, 1, 1);
    drive();
    step();
    step();
    reset = 1'b0;
    wait_drain("t6_after_reset_drain");

    check("final_scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
